// File: rtl/seg7_pkg.sv
// Shared seven-segment constants and BCD limits.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam int unsigned SEG_W = 7;
    localparam int unsigned BCD_W = 4;

    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

endpackage : seg7_pkg

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low seven-segment decoder.
// Ports:
//   bcd_i  - 4-bit BCD digit
//   seg_o  - segments {g,f,e,d,c,b,a}, active-low; non-decimal codes blank
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_i,
    output logic [SEG_W-1:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule : seg7_decode

// File: rtl/bcd_tick_counter.sv
// Multi-digit decimal counter with prescaler, up/down, parallel load and
// per-digit seven-segment decode.
// Ports:
//   CLOCK_50   - clock, rising edge
//   reset      - synchronous active-high reset
//   en         - count enable (freezes prescaler and digits when low)
//   up         - 1 counts up, 0 counts down
//   load       - parallel load strobe (beats a tick step)
//   load_value - BCD digits to load; nibbles above 9 are stored as 0
//   bcd        - registered count, digit 0 in the low nibble
//   hex        - active-low segments per digit, decoded from bcd
//   tick       - one-cycle pulse on each count step
//   wrap       - one-cycle pulse when the count wraps
module bcd_tick_counter
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    up,
    input  logic                    load,
    input  logic [BCD_W*DIGITS-1:0] load_value,
    output logic [BCD_W*DIGITS-1:0] bcd,
    output logic [SEG_W*DIGITS-1:0] hex,
    output logic                    tick,
    output logic                    wrap
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned BW = BCD_W * DIGITS;
    localparam logic [PW-1:0] TERM = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [BW-1:0] bcd_q,   bcd_d;
    logic          tick_q,  tick_d;
    logic          wrap_q,  wrap_d;

    logic [BW-1:0]   stepped_c;
    logic [BW-1:0]   load_clean_c;
    // chain_c[i] high means digit i receives a carry (up) or borrow (down)
    logic [DIGITS:0] chain_c;

    assign chain_c[0] = 1'b1;

    // Per-digit step, carry/borrow ripple and load sanitising
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        logic [BCD_W-1:0] cur_c;
        logic [BCD_W-1:0] ld_c;
        logic             at_lim_c;

        assign cur_c    = bcd_q[BCD_W*gi +: BCD_W];
        assign ld_c     = load_value[BCD_W*gi +: BCD_W];
        assign at_lim_c = up ? (cur_c == BCD_MAX) : (cur_c == 4'd0);

        assign chain_c[gi+1] = chain_c[gi] & at_lim_c;

        assign stepped_c[BCD_W*gi +: BCD_W] =
            !chain_c[gi] ? cur_c :
            at_lim_c     ? (up ? 4'd0 : BCD_MAX) :
            up           ? 4'(cur_c + 4'd1) : 4'(cur_c - 4'd1);

        assign load_clean_c[BCD_W*gi +: BCD_W] = (ld_c > BCD_MAX) ? 4'd0 : ld_c;

        seg7_decode u_dec (
            .bcd_i (cur_c),
            .seg_o (hex[SEG_W*gi +: SEG_W])
        );
    end

    // Next-state: load beats a terminal-count step
    always_comb begin
        presc_d = presc_q;
        bcd_d   = bcd_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        if (load) begin
            bcd_d   = load_clean_c;
            presc_d = '0;
        end else if (en) begin
            if (presc_q == TERM) begin
                presc_d = '0;
                bcd_d   = stepped_c;
                tick_d  = 1'b1;
                // carry/borrow falling off the top digit is a wrap
                wrap_d  = chain_c[DIGITS];
            end else begin
                presc_d = PW'(presc_q + PW'(1));
            end
        end
    end

    // State registers, synchronous reset
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            presc_q <= '0;
            bcd_q   <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            bcd_q   <= bcd_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bcd  = bcd_q;
    assign tick = tick_q;
    assign wrap = wrap_q;

endmodule : bcd_tick_counter

// File: tb/tb_bcd_tick_counter.sv
// Bench for bcd_tick_counter with DIGITS=2, TICK_DIV=4: directed scenarios
// followed by random stimulus, all checked against an integer count model.
module tb_bcd_tick_counter;

    localparam int unsigned DIGITS   = 2;
    localparam int unsigned TICK_DIV = 4;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        up = 1'b1;
    logic        load = 1'b0;
    logic [7:0]  load_value = 8'h00;
    logic [7:0]  bcd;
    logic [13:0] hex;
    logic        tick;
    logic        wrap;

    int tests = 0;
    int fails = 0;

    // Reference model: count as an integer 0..99, prescaler as an integer
    int m_cnt = 0;
    int m_pre = 0;
    bit m_tick = 1'b0;
    bit m_wrap = 1'b0;

    logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100,
                                  7'b0110000, 7'b0011001, 7'b0010010,
                                  7'b0000010, 7'b1111000, 7'b0000000,
                                  7'b0010000};

    bcd_tick_counter #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV)) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .en         (en),
        .up         (up),
        .load       (load),
        .load_value (load_value),
        .bcd        (bcd),
        .hex        (hex),
        .tick       (tick),
        .wrap       (wrap)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic int clean_val(input logic [7:0] lv);
        int t, o;
        t = (lv[7:4] > 4'd9) ? 0 : int'(lv[7:4]);
        o = (lv[3:0] > 4'd9) ? 0 : int'(lv[3:0]);
        return t * 10 + o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle, advance the model on the edge, then compare outputs
    task automatic step(input bit r, input bit e, input bit u, input bit l,
                        input logic [7:0] lv);
        logic [7:0]  exp_bcd;
        logic [13:0] exp_hex;
        reset = r; en = e; up = u; load = l; load_value = lv;
        @(posedge CLOCK_50);
        if (r) begin
            m_cnt = 0; m_pre = 0; m_tick = 0; m_wrap = 0;
        end else if (l) begin
            m_cnt = clean_val(lv); m_pre = 0; m_tick = 0; m_wrap = 0;
        end else if (e && m_pre == TICK_DIV - 1) begin
            m_pre  = 0;
            m_tick = 1;
            if (u) begin
                m_wrap = (m_cnt == 99);
                m_cnt  = (m_cnt + 1) % 100;
            end else begin
                m_wrap = (m_cnt == 0);
                m_cnt  = (m_cnt + 99) % 100;
            end
        end else begin
            m_tick = 0; m_wrap = 0;
            if (e) m_pre = m_pre + 1;
        end
        #1;
        exp_bcd = {4'(m_cnt / 10), 4'(m_cnt % 10)};
        exp_hex = {seg_tab[m_cnt / 10], seg_tab[m_cnt % 10]};
        chk("bcd",  32'(bcd),  32'(exp_bcd));
        chk("tick", 32'(tick), 32'(m_tick));
        chk("wrap", 32'(wrap), 32'(m_wrap));
        chk("hex",  32'(hex),  32'(exp_hex));
    endtask

    initial begin
        int tick_cnt;
        // Reset
        step(1, 0, 1, 0, 8'h00);
        step(1, 0, 1, 0, 8'h00);
        chk("reset_bcd", 32'(bcd), 32'h00);
        chk("reset_hex", 32'(hex), 32'(14'b1000000_1000000));

        // Count up 40 cycles: ten ticks, one every fourth cycle
        tick_cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            step(0, 1, 1, 0, 8'h00);
            chk("tick_phase", 32'(tick), 32'((i % 4) == 0));
            if (tick) tick_cnt++;
        end
        chk("tick_count", 32'(tick_cnt), 32'd10);
        chk("up40_bcd", 32'(bcd), 32'h10);
        chk("up40_hex", 32'(hex), 32'(14'b1111001_1000000));

        // Load 98, count up through 99 to 00 with wrap
        step(0, 1, 1, 1, 8'h98);
        for (int i = 1; i <= 8; i++) begin
            step(0, 1, 1, 0, 8'h00);
            if (i == 4) chk("up_99", 32'(bcd), 32'h99);
            if (i == 4) chk("no_wrap_99", 32'(wrap), 32'd0);
            if (i == 8) chk("up_wrap_bcd", 32'(bcd), 32'h00);
            if (i == 8) chk("up_wrap", 32'(wrap), 32'd1);
        end

        // Load 00, one down step wraps to 99
        step(0, 1, 0, 1, 8'h00);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 8'h00);
        chk("down_wrap_bcd", 32'(bcd), 32'h99);
        chk("down_wrap", 32'(wrap), 32'd1);

        // Invalid nibble cleared; full period before first tick
        step(0, 1, 1, 1, 8'h3F);
        chk("load_clean", 32'(bcd), 32'h30);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 0, 8'h00);
            chk("post_load_no_tick", 32'(tick), 32'd0);
        end
        step(0, 1, 1, 0, 8'h00);
        chk("post_load_tick", 32'(bcd), 32'h31);

        // Freeze at prescaler 2 for 10 cycles
        step(0, 1, 1, 1, 8'h50);
        step(0, 1, 1, 0, 8'h00);
        step(0, 1, 1, 0, 8'h00);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1, 0, 8'h00);
            chk("frozen_bcd", 32'(bcd), 32'h50);
            chk("frozen_tick", 32'(tick), 32'd0);
        end
        step(0, 1, 1, 0, 8'h00);
        chk("resume_no_tick", 32'(tick), 32'd0);
        step(0, 1, 1, 0, 8'h00);
        chk("resume_tick", 32'(tick), 32'd1);
        chk("resume_bcd", 32'(bcd), 32'h51);

        // Reset + load + terminal count on one cycle
        step(0, 1, 1, 1, 8'h27);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 8'h00);
        step(1, 1, 1, 1, 8'h55);
        chk("rst_over_bcd", 32'(bcd), 32'h00);
        chk("rst_over_tick", 32'(tick), 32'd0);
        chk("rst_over_wrap", 32'(wrap), 32'd0);

        // Load on terminal-count cycle: no step, no tick
        step(0, 1, 1, 1, 8'h27);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 8'h00);
        step(0, 1, 1, 1, 8'h42);
        chk("load_tc_bcd", 32'(bcd), 32'h42);
        chk("load_tc_tick", 32'(tick), 32'd0);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 8'h00);
        chk("load_tc_next", 32'(bcd), 32'h43);

        // Random stimulus against the model
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 3) != 0),
                 1'($urandom),
                 ($urandom_range(0, 29) == 0),
                 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_bcd_tick_counter

// File: doc/bcd_tick_counter.md
# bcd_tick_counter

Parametrised multi-digit decimal counter with a built-in prescaler, up/down mode, parallel load and per-digit seven-segment outputs. It is the general form of the single-digit, fixed one-second display counter: digit count and tick period are configurable, and the counter can count down, pause and preload. It sits between the board clock and the HEX displays, and also feeds count and wrap status to other logic.

## Interface

Parameters:

- DIGITS, 4: number of BCD digits (1..8); digit 0 is least significant.
- TICK_DIV, 50_000_000: clock cycles per count step; must be ≥1.

Ports:

- CLOCK_50  in  1  — single clock; all state updates on its rising edge.
- reset  in  1  — synchronous, active-high reset.
- en  in  1  — count enable; low freezes both prescaler and digits.
- up  in  1  — direction: 1 counts up, 0 counts down; sampled on the tick cycle.
- load  in  1  — parallel load strobe.
- load_value  in  4*DIGITS  — BCD digits to load; digit i is in bits [4i+3:4i].
- bcd  out  4*DIGITS  — current count, registered.
- hex  out  7*DIGITS  — active-low segments {g,f,e,d,c,b,a} per digit; digit i is in bits [7i+6:7i].
- tick  out  1  — one-cycle pulse on each count step.
- wrap  out  1  — one-cycle pulse when the count wraps.

## Operation

- The prescaler counts 0..TICK_DIV-1 while en=1 and holds while en=0.
- On a cycle where en=1 and the prescaler equals TICK_DIV-1:
  - prescaler returns to 0;
  - tick=1;
  - the digits take one step in the direction given by up.
- Up step:
  - digit 0 increments;
  - a digit at 9 becomes 0 and carries into the next digit.
- Down step:
  - digit 0 decrements;
  - a digit at 0 becomes 9 and borrows from the next digit.
- Wrap:
  - all 9s going up → all 0s, and wrap=1 on that step;
  - all 0s going down → all 9s, and wrap=1 on that step.
- Priority per cycle: reset > load > tick step.
- load=1:
  - bcd ← load_value and prescaler ← 0;
  - tick=0 and wrap=0 that cycle, even if the prescaler was at terminal count.
  - Any loaded nibble > 9 is stored as 0.
- reset=1: prescaler=0, bcd=0, tick=0, wrap=0. hex then shows "0" on every digit (7'b1000000).
- hex is a combinational decode of registered bcd:
  - 0–9 use the standard active-low patterns (1=1111001, 8=0000000, 9=0010000);
  - any other code gives 1111111 (blank). This cannot occur in normal operation.
- tick and wrap are registered and high for exactly one cycle per event.

## Timing

- Prescaler width is $clog2(TICK_DIV), minimum 1 bit.
- With TICK_DIV=1, a step occurs on every enabled cycle.
- Tick period is exactly TICK_DIV enabled cycles. en-low cycles stretch the period and do not reset it.
- Latency: bcd, tick and wrap all change on the same rising edge, the one where the prescaler held TICK_DIV-1. hex follows bcd in that same cycle.
- Load takes effect on the next edge. The first step after a load comes TICK_DIV enabled cycles later.
- A change of up between ticks only affects the next step; there is no glitch on bcd.
- Reset asserted mid-interval discards the partial prescaler count. After release, the first tick comes TICK_DIV enabled cycles later.
- load and en together: the load wins and the prescaler restarts from 0.

## Structure

- Shared package `seg7_pkg`: active-low segment constants SEG_0..SEG_9 and SEG_BLANK, and the BCD_MAX=4'd9 constant.
- Sub-module `seg7_decode` (4-bit in, 7-bit out, combinational), instantiated DIGITS times in a generate loop.
- Digit carry/borrow chain is a generate loop in the top module. No separate module is needed for it.

## Test plan

All scenarios use DIGITS=2, TICK_DIV=4.

- Reset then en=1, up=1 for 40 cycles:
  - tick on cycles 4, 8, …;
  - bcd reaches 8'h10 after 10 ticks;
  - hex[6:0] = 1000000 and hex[13:7] = 1111001.
- Load 8'h98, up=1, run 8 cycles:
  - bcd goes 99, then 00;
  - wrap=1 exactly on the 99→00 edge.
- Load 8'h00, up=0, one tick:
  - bcd=8'h99 and wrap=1.
- Load 8'h3F:
  - bcd=8'h30 (invalid nibble cleared);
  - no tick for the next 3 enabled cycles.
- en toggled low for 10 cycles at prescaler=2:
  - bcd and prescaler are frozen;
  - the tick arrives 2 enabled cycles after en returns high.
- Edge-case overlaps:
  - reset asserted on the same cycle as terminal count and load → bcd=0, tick=0, wrap=0;
  - load on a terminal-count cycle → loaded value, with no step and no tick.
